// File: rtl/gshare_predictor_p.sv
// Gshare branch predictor: global history XOR-folded into the PC indexes a table of saturating counters.
// Optional GSHARE_STATS_EN adds free-running prediction and mispredict counters.
module gshare_predictor_p #(
    parameter int HIST_W   = 7,
    parameter int PC_W     = 7,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 2**(CTR_W-1)-1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              predict_valid,
    input  logic [PC_W-1:0]   predict_pc,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_history,
    input  logic              train_valid,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    input  logic [HIST_W-1:0] train_history,
`ifdef GSHARE_STATS_EN
    output logic [31:0]       stat_predicts,
    output logic [31:0]       stat_mispredicts,
`endif
    input  logic [PC_W-1:0]   train_pc
);

    localparam int DEPTH  = 2**PC_W;
    localparam int NSLICE = (HIST_W + PC_W - 1) / PC_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0]  pht [DEPTH];
    logic [HIST_W-1:0] hist_r;
    logic [PC_W-1:0]   predict_idx;
    logic [PC_W-1:0]   train_idx;
    logic [CTR_W-1:0]  train_ctr;
    logic [CTR_W-1:0]  train_ctr_next;

    // The top slice is zero-extended before being XORed in.
    function automatic logic [PC_W-1:0] fold(input logic [HIST_W-1:0] h);
        logic [NSLICE*PC_W-1:0] ext;
        logic [PC_W-1:0]        acc;
        ext = '0;
        ext[HIST_W-1:0] = h;
        acc = '0;
        for (int i = 0; i < NSLICE; i++) begin
            acc = acc ^ ext[i*PC_W +: PC_W];
        end
        return acc;
    endfunction

    assign predict_idx     = predict_pc ^ fold(hist_r);
    assign train_idx       = train_pc ^ fold(train_history);
    assign predict_taken   = predict_valid & pht[predict_idx][CTR_W-1];
    assign predict_history = predict_valid ? hist_r : '0;

    always_comb begin
        train_ctr      = pht[train_idx];
        train_ctr_next = train_ctr;
        if (train_taken && train_ctr != CTR_MAX) begin
            train_ctr_next = train_ctr + 1'b1;
        end else if (!train_taken && train_ctr != '0) begin
            train_ctr_next = train_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (train_valid) begin
            pht[train_idx] <= train_ctr_next;
        end
    end

    // Mispredict recovery takes priority over the speculative shift.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hist_r <= '0;
        end else if (train_valid && train_mispredicted) begin
            hist_r <= {train_history[HIST_W-2:0], train_taken};
        end else if (predict_valid) begin
            hist_r <= {hist_r[HIST_W-2:0], predict_taken};
        end
    end

`ifdef GSHARE_STATS_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            stat_predicts    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (predict_valid) begin
                stat_predicts <= stat_predicts + 32'd1;
            end
            if (train_valid && train_mispredicted) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gshare_predictor_p.sv
// Directed-vector bench for gshare_predictor_p: default 7/7 instance plus a 12-bit-history instance.
module tb_gshare_predictor_p;

    logic        clk;
    logic        areset;
    logic        predict_valid;
    logic [6:0]  predict_pc;
    logic        train_valid;
    logic        train_taken;
    logic        train_mispredicted;
    logic [11:0] train_history;
    logic [6:0]  train_pc;

    logic        taken7;
    logic [6:0]  hist7;
    logic        taken12;
    logic [11:0] hist12;
`ifdef GSHARE_STATS_EN
    logic [31:0] stat_predicts;
    logic [31:0] stat_mispredicts;
    logic [31:0] stat_predicts12;
    logic [31:0] stat_mispredicts12;
`endif

    int n_vectors;
    int n_fails;

    typedef struct {
        logic       pv;
        logic [6:0] ppc;
        logic       tv;
        logic       tt;
        logic       tm;
        logic [6:0] th;
        logic [6:0] tpc;
        logic       exp_taken;
        logic [6:0] exp_hist;
    } vec_t;

    vec_t vecs[23];

    gshare_predictor_p dut (
        .clk(clk), .areset(areset),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .predict_taken(taken7), .predict_history(hist7),
        .train_valid(train_valid), .train_taken(train_taken),
        .train_mispredicted(train_mispredicted), .train_history(train_history[6:0]),
`ifdef GSHARE_STATS_EN
        .stat_predicts(stat_predicts), .stat_mispredicts(stat_mispredicts),
`endif
        .train_pc(train_pc)
    );

    gshare_predictor_p #(.HIST_W(12), .PC_W(7)) dut12 (
        .clk(clk), .areset(areset),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .predict_taken(taken12), .predict_history(hist12),
        .train_valid(train_valid), .train_taken(train_taken),
        .train_mispredicted(train_mispredicted), .train_history(train_history),
`ifdef GSHARE_STATS_EN
        .stat_predicts(stat_predicts12), .stat_mispredicts(stat_mispredicts12),
`endif
        .train_pc(train_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic pv, input logic [6:0] ppc, input logic tv,
                                 input logic tt, input logic tm, input logic [11:0] th,
                                 input logic [6:0] tpc);
        @(negedge clk);
        predict_valid      = pv;
        predict_pc         = ppc;
        train_valid        = tv;
        train_taken        = tt;
        train_mispredicted = tm;
        train_history      = th;
        train_pc           = tpc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        areset = 1'b1;
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 12'h000, 7'h00);
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        n_vectors = 0;
        n_fails   = 0;
        areset    = 1'b1;
        predict_valid = 1'b1; predict_pc = 7'h05;
        train_valid = 1'b0; train_taken = 1'b0; train_mispredicted = 1'b0;
        train_history = '0; train_pc = '0;

        // Columns: pv, ppc, tv, tt, tm, th, tpc, exp_taken, exp_hist
        vecs[0]  = '{1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00};
        vecs[1]  = '{1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00};
        vecs[2]  = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 7'h05, 1'b0, 7'h00};
        vecs[3]  = '{1'b1, 7'h05, 1'b1, 1'b1, 1'b0, 7'h00, 7'h05, 1'b1, 7'h00};
        vecs[4]  = '{1'b1, 7'h04, 1'b1, 1'b1, 1'b0, 7'h00, 7'h05, 1'b1, 7'h01};
        vecs[5]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h05, 1'b0, 7'h00};
        vecs[6]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h05, 1'b0, 7'h00};
        vecs[7]  = '{1'b1, 7'h06, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h03};
        vecs[8]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h10, 1'b0, 7'h00};
        vecs[9]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h10, 1'b0, 7'h00};
        vecs[10] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h10, 1'b0, 7'h00};
        vecs[11] = '{1'b1, 7'h16, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h06};
        vecs[12] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 7'h10, 1'b0, 7'h00};
        vecs[13] = '{1'b1, 7'h1C, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h0C};
        vecs[14] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 7'h10, 1'b0, 7'h00};
        vecs[15] = '{1'b1, 7'h08, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b1, 7'h18};
        vecs[16] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 7'h0A, 7'h00, 1'b0, 7'h00};
        vecs[17] = '{1'b1, 7'h00, 1'b1, 1'b1, 1'b1, 7'h2A, 7'h00, 1'b0, 7'h15};
        vecs[18] = '{1'b1, 7'h5F, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b1, 7'h55};
        vecs[19] = '{1'b1, 7'h01, 1'b0, 1'b0, 1'b1, 7'h7F, 7'h00, 1'b1, 7'h2B};
        vecs[20] = '{1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h57};
        vecs[21] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00};
        vecs[22] = '{1'b1, 7'h2B, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h2E};

        #2;
        checkOutput("reset_taken", {31'd0, taken7}, 32'd0);
        checkOutput("reset_hist", {25'd0, hist7}, 32'd0);
        @(negedge clk);
        areset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].ppc, vecs[i].tv, vecs[i].tt, vecs[i].tm,
                          {5'd0, vecs[i].th}, vecs[i].tpc);
            #1;
            checkOutput($sformatf("vec%0d_taken", i), {31'd0, taken7}, {31'd0, vecs[i].exp_taken});
            checkOutput($sformatf("vec%0d_hist", i), {25'd0, hist7}, {25'd0, vecs[i].exp_hist});
        end

        // Asynchronous reset mid-cycle, with train/predict traffic held during it.
        applyStimulus(1'b1, 7'h0A, 1'b1, 1'b1, 1'b0, 12'h000, 7'h0A);
        #2;
        areset = 1'b1;
        #1;
        checkOutput("async_rst_hist", {25'd0, hist7}, 32'd0);
        checkOutput("async_rst_taken", {31'd0, taken7}, 32'd0);
        applyStimulus(1'b1, 7'h0A, 1'b0, 1'b0, 1'b0, 12'h000, 7'h00);
        areset = 1'b0;
        #1;
        checkOutput("post_rst_taken", {31'd0, taken7}, 32'd0);
        checkOutput("post_rst_hist", {25'd0, hist7}, 32'd0);

        // Wide-history instance: fold(0xF80) = 0x1F, so pc 0x01 indexes entry 0x1E.
        doReset();
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 12'h7C0, 7'h00);
        applyStimulus(1'b1, 7'h01, 1'b1, 1'b1, 1'b0, 12'hF80, 7'h01);
        #1;
        checkOutput("w12_pre_taken", {31'd0, taken12}, 32'd0);
        checkOutput("w12_pre_hist", {20'd0, hist12}, 32'hF80);
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 12'h7C0, 7'h00);
        applyStimulus(1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 12'h000, 7'h00);
        #1;
        checkOutput("w12_post_taken", {31'd0, taken12}, 32'd1);
        checkOutput("w12_post_hist", {20'd0, hist12}, 32'hF80);

`ifdef GSHARE_STATS_EN
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 7'(i), (i < 3), 1'b0, 1'b1, 12'h000, 7'h00);
        end
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 12'h000, 7'h00);
        #1;
        checkOutput("stat_predicts", stat_predicts, 32'd10);
        checkOutput("stat_mispredicts", stat_mispredicts, 32'd3);
        areset = 1'b1;
        #1;
        checkOutput("stat_predicts_rst", stat_predicts, 32'd0);
        checkOutput("stat_mispredicts_rst", stat_mispredicts, 32'd0);
        @(negedge clk);
        areset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fails);
        $finish;
    end

endmodule
